// File: rtl/led_frame_sched.sv
// led_frame_sched: frame scheduler and arbiter for the serial LED shift driver.
// Two requesters (CPU, debug) compete once per frame for a shadow register.
// At each frame boundary the driver is restarted and sees a fresh 16-bit pattern.
// Optional macro LED_ARB_RR_EN: round-robin arbitration instead of debug-first priority.
// The grant is registered at fcnt=P-2, so the requests sampled in that cycle decide it.
// The ack is then visible during fcnt=P-1, and the winner's data is captured at the end of that cycle.
module led_frame_sched #(
    parameter int P_FRAME_CYCLES = 18
) (
    input  logic        i_CLK,
    input  logic        i_RESET,
    input  logic        i_Enable,
    input  logic        i_Blank,
    input  logic        i_CpuReq,
    input  logic [15:0] i_CpuData,
    output logic        o_CpuAck,
    input  logic        i_DbgReq,
    input  logic [15:0] i_DbgData,
    output logic        o_DbgAck,
    output logic [15:0] o_Data16,
    output logic        o_DrvReset,
    output logic        o_FrameDone,
    output logic        o_Busy
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [7:0] LAST = 8'(P_FRAME_CYCLES - 1);
    localparam logic [7:0] PRE  = 8'(P_FRAME_CYCLES - 2);

    state_t      state_q, state_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [15:0] shadow_q, data_q, shadow_nx;
    logic        cpu_ack_q, dbg_ack_q;
    logic        load, arb_eval, frame_end;
    logic        grant_cpu, grant_dbg;

`ifdef LED_ARB_RR_EN
    logic        last_dbg_q;
`endif

    // Next-state and frame-position decode
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        load      = 1'b0;
        arb_eval  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Enable) begin
                    state_d = S_RUN;
                    fcnt_d  = 8'd0;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (fcnt_q == LAST) begin
                    frame_end = 1'b1;
                    fcnt_d    = 8'd0;
                    if (i_Enable) load = 1'b1;
                    else          state_d = S_IDLE;
                end else begin
                    fcnt_d   = fcnt_q + 8'd1;
                    arb_eval = (fcnt_q == PRE);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arbitration between the two requesters and the shadow value committed at frame end
    always_comb begin
`ifdef LED_ARB_RR_EN
        grant_dbg = i_DbgReq && (!i_CpuReq || !last_dbg_q);
`else
        grant_dbg = i_DbgReq;
`endif
        grant_cpu = i_CpuReq && !grant_dbg;
        // ack regs are only ever set during the last frame cycle, so outside it this is shadow_q
        shadow_nx = cpu_ack_q ? i_CpuData : (dbg_ack_q ? i_DbgData : shadow_q);
    end

    // State, frame counter, grant pulses, shadow and driver pattern registers
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q   <= S_IDLE;
            fcnt_q    <= 8'd0;
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            shadow_q  <= 16'h0000;
            data_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            cpu_ack_q <= arb_eval && grant_cpu;
            dbg_ack_q <= arb_eval && grant_dbg;
            if (frame_end) shadow_q <= shadow_nx;
            if (load)      data_q   <= i_Blank ? 16'h0000 : shadow_nx;
        end
    end

`ifdef LED_ARB_RR_EN
    // Last-grant pointer; resets to "CPU last" so debug takes the first tie
    always_ff @(posedge i_CLK) begin
        if (i_RESET)                                 last_dbg_q <= 1'b0;
        else if (arb_eval && (grant_cpu || grant_dbg)) last_dbg_q <= grant_dbg;
    end
`endif

    assign o_CpuAck    = cpu_ack_q;
    assign o_DbgAck    = dbg_ack_q;
    assign o_Data16    = data_q;
    assign o_Busy      = (state_q == S_RUN);
    assign o_DrvReset  = (state_q == S_IDLE) || (fcnt_q == 8'd0);
    assign o_FrameDone = (state_q == S_RUN) && (fcnt_q == LAST);

endmodule

// File: doc/led_frame_sched.md
# led_frame_sched

Frame scheduler and arbiter for the serial LED shift driver. It shares the 16-LED display between two requesters: the CPU register port and the debug port. It double-buffers the winning pattern and holds the driver's 16-bit data input stable for a whole frame. It also restarts the driver at every frame boundary through the driver's reset, so each frame starts with a clean shift and ends with the driver's latch.

## Interface
Parameters:
- P_FRAME_CYCLES, 18: cycles per frame; legal range 18..255.
  - 18 is the driver minimum: 1 restart cycle, 1 warm-up cycle and 16 shift cycles.

Ports:
- i_CLK  in  1  clock, shared with the LED driver.
- i_RESET  in  1  reset: i_RESET, synchronous, active-high; clock i_CLK.
- i_Enable  in  1  run frames; when low, the block halts at the end of the current frame.
- i_Blank  in  1  when high at a frame load, the block loads 16'h0000 instead of the shadow value.
- i_CpuReq  in  1  CPU request; held high with i_CpuData stable until o_CpuAck.
- i_CpuData  in  16  CPU LED pattern.
- o_CpuAck  out  1  one-cycle grant pulse; i_CpuData is captured into the shadow register in this cycle.
- i_DbgReq  in  1  debug request; same rules as the CPU request.
- i_DbgData  in  16  debug LED pattern.
- o_DbgAck  out  1  one-cycle grant pulse for the debug port.
- o_Data16  out  16  pattern to the driver; changes only in a cycle where o_DrvReset=1.
- o_DrvReset  out  1  restart/hold for the driver; active-high.
- o_FrameDone  out  1  one-cycle pulse on the last cycle of each frame.
- o_Busy  out  1  high while the block is in RUN.

## Operation
- State IDLE:
  - o_DrvReset=1.
  - If i_Enable=1, the next state is RUN with fcnt=0; otherwise the block stays in IDLE.
- State RUN: 8-bit fcnt increments every cycle, 0..P_FRAME_CYCLES-1, then wraps to 0.
- Cycle fcnt=0:
  - o_DrvReset=1.
  - o_Data16 loads `i_Blank ? 16'h0000 : shadow`.
- Cycles fcnt=1..P-1: o_DrvReset=0 and o_Data16 is frozen.
- Cycle fcnt=P-1:
  - o_FrameDone=1.
  - Arbitration is evaluated; the winner's Ack=1 and its data is written to shadow.
  - If nobody requests, shadow is unchanged and the frame refreshes the previous pattern.
  - If i_Enable=0, the next state is IDLE; otherwise the next state is RUN with fcnt=0.
- Grants: at most one Ack per frame; no Ack is ever issued outside fcnt=P-1.
- A request dropped before its Ack is simply lost; there is no error.
- i_Blank does not block grants; blanked data is still written to shadow.
- i_Enable falling mid-frame: the frame completes normally, including its grant, then the block goes to IDLE.

## Timing
- Reset values:
  - State IDLE, fcnt=0.
  - o_Data16=16'h0000, shadow=16'h0000.
  - o_DrvReset=1, o_CpuAck=0, o_DbgAck=0, o_FrameDone=0, o_Busy=0.
- Reset mid-frame: the block returns to these values on the next edge. Pending requests are not acked; the requester must keep holding its request.
- All outputs are registered or decoded from registers only. There are no combinational paths from inputs to outputs.
- Grant latency: request seen at fcnt=k → Ack at fcnt=P-1 of the same frame. Worst case is P cycles when the request arrives just after the grant cycle.
- Display latency: o_Data16 shows the granted pattern 1 cycle after its Ack, at fcnt=0 of the next frame.
- Enable latency: i_Enable rising in IDLE → o_Busy=1 and fcnt=0 on the next cycle.

## Configuration
- LED_ARB_RR_EN undefined: fixed priority; debug beats CPU on simultaneous requests.
- LED_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer is kept.
  - On simultaneous requests, the grant goes to the port not granted last.
  - A single requester always wins.
  - The pointer resets to "CPU last", so debug wins the first tie.

## Test plan
- Reset, then i_Enable=1: o_DrvReset=1 until RUN fcnt=0. With P=18, o_FrameDone pulses every 18 cycles and o_Data16=0000 throughout.
- CPU request 0xA5A5 at fcnt=3: o_CpuAck at fcnt=17; o_Data16=A5A5 at the next fcnt=0 with o_DrvReset=1; o_Data16 is frozen for the following 17 cycles.
- Simultaneous requests, CPU 0x1111 and debug 0x2222, held for 2 frames:
  - Without the macro: DbgAck in frame 1, CpuAck in frame 2, so o_Data16 shows 2222 then 1111.
  - With LED_ARB_RR_EN: same order, and a third contested frame grants debug again.
- i_Blank=1 around a load with shadow=0x00FF: o_Data16=0000. Next frame with i_Blank=0: o_Data16=00FF with no new request.
- i_Enable dropped at fcnt=5: the frame completes (FrameDone at fcnt=17), then IDLE with o_Busy=0 and o_DrvReset=1.
- i_RESET pulsed at fcnt=10 while CPU 0xBEEF is pending: all outputs return to reset values and no Ack is issued. After reset release and i_Enable=1, o_CpuAck occurs at the first fcnt=17.
